wm8960_init_seq: RTL and testbench
==================================

WM8960_INIT_SEQ -- requirements
Module: wm8960_init_seq

Interface
REQ-001 The block SHALL have parameter G_DEVICE_ADDRESS, default 7'h1A, the 7-bit codec address placed on every command.
REQ-002 The block SHALL have parameter G_POWERUP_CYCLES, default 1000, the clk cycles waited after start before the first command.
REQ-003 The block SHALL have parameter G_GAP_CYCLES, default 100, the clk cycles waited between consecutive commands.
REQ-004 The block SHALL have parameter G_MAX_RETRIES, default 3, the retry budget per table entry after a failed ack.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; one clock, all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-007 The block SHALL have port enable, input, 1 bit; low behaves as reset.
REQ-008 The block SHALL have port start, input, 1 bit; a one-cycle pulse begins the sequence.
REQ-009 The block SHALL have output busy (1), done (1), error (1) and fail_index (8), the sequence status.
REQ-010 The block SHALL have outputs cmd_device_address (7), cmd_rd_wr (1), cmd_register_address (7), cmd_register_data (9) and cmd_valid (1), plus input cmd_ready (1), the command stream to the I2C master.
REQ-011 The block SHALL have inputs rsp_register_data (9), rsp_acks_received (3) and rsp_valid (1), plus output rsp_ready (1), the I2C master result stream.

Function
REQ-012 The block SHALL walk the init table from the shared package (C_INIT_NUM_REGS entries, each a 7-bit address and 9-bit data) from index 0 upward.
REQ-013 The state machine SHALL use states S_IDLE, S_POWERUP, S_ISSUE, S_WAIT_RSP, S_GAP, S_DONE and S_ERROR.
REQ-014 In S_IDLE, a start pulse SHALL move the block to S_POWERUP, clear the index, retry count, done, error and fail_index, and set busy.
REQ-015 The block SHALL remain in S_POWERUP for exactly G_POWERUP_CYCLES cycles, then enter S_ISSUE.
REQ-016 In S_ISSUE, cmd_valid SHALL be 1 with cmd_rd_wr=0 and the current table entry, held stable until the cycle where cmd_valid and cmd_ready are both 1; the block then drops cmd_valid and enters S_WAIT_RSP.
REQ-017 In S_WAIT_RSP, rsp_ready SHALL be 1, and it SHALL be 0 in every other state.
REQ-018 On rsp_valid and rsp_ready with rsp_acks_received=3'b111, the block SHALL increment the index, clear the retry count, and enter S_GAP.
REQ-019 On a response with any ack bit 0 and retry count below G_MAX_RETRIES, the block SHALL increment the retry count, keep the index, and enter S_GAP; the same entry is then re-issued.
REQ-020 On a response with any ack bit 0 and retry count equal to G_MAX_RETRIES, the block SHALL load fail_index with the index and enter S_ERROR.
REQ-021 The block SHALL remain in S_GAP for exactly G_GAP_CYCLES cycles, then enter S_DONE if the index equals C_INIT_NUM_REGS, otherwise S_ISSUE.
REQ-022 In S_DONE, done SHALL be 1 and busy 0; in S_ERROR, error SHALL be 1 and busy 0; both are sticky until the next start or reset.
REQ-023 A start pulse in S_DONE or S_ERROR SHALL restart the sequence as in S_IDLE, and a start pulse while busy SHALL be ignored.
REQ-024 The delay counters SHALL be 16-bit; a parameter value of 0 SHALL be treated as 1 cycle.
REQ-025 A response arriving outside S_WAIT_RSP SHALL NOT be consumed.

Reset
REQ-026 While reset=0 or enable=0, every output SHALL be 0 except cmd_device_address, which SHALL be G_DEVICE_ADDRESS, and the state SHALL be S_IDLE.
REQ-027 Reset or enable=0 asserted mid-transaction SHALL abort immediately without completing the handshake.

Configuration
REQ-028 With macro WM8960_INIT_READBACK_EN defined, each fully acked write SHALL be followed by a read command (cmd_rd_wr=1, same address) with its own S_RB_ISSUE and S_RB_WAIT states.
REQ-029 Under WM8960_INIT_READBACK_EN, a readback whose rsp_register_data differs from the written data, or which is not fully acked, SHALL count as a failed attempt under the REQ-019 and REQ-020 retry rules.
REQ-030 With WM8960_INIT_READBACK_EN undefined, the readback states and logic SHALL NOT be present.

Structure
REQ-031 Package wm8960_pkg SHALL hold the state_t enum, the C_INIT_NUM_REGS constant, the init table constant array, and C_WM8960_ADDR.
REQ-032 The block SHALL contain one sub-module, wm8960_delay_cnt, a loadable down-counter with a done pulse, shared by S_POWERUP and S_GAP.

Verification
REQ-033 Bench scenario: reset=0 for 5 cycles -> all outputs zero, cmd_device_address=7'h1A.
REQ-034 Bench scenario: start with a responder that always returns acks=3'b111 -> C_INIT_NUM_REGS commands in table order, then done=1 and busy=0.
REQ-035 Bench scenario: entry 2 returns acks=3'b101 twice, then 3'b111 -> entry 2 issued 3 times, sequence completes, error=0.
REQ-036 Bench scenario: entry 4 always returns acks=3'b011 with G_MAX_RETRIES=3 -> exactly 4 attempts, error=1, fail_index=4.
REQ-037 Bench scenario: cmd_ready held low for 50 cycles -> cmd_valid stays high with stable fields, and exactly one command is transferred when cmd_ready rises.
REQ-038 Bench scenario: reset=0 pulsed during S_WAIT_RSP -> S_IDLE next cycle, then a fresh start sends index 0 first.

Source files
------------

// File: rtl/wm8960_pkg.sv
// Shared types and the WM8960 power-on register table.
// Readback states exist only when WM8960_INIT_READBACK_EN is defined.
package wm8960_pkg;

    localparam logic [6:0]  C_WM8960_ADDR   = 7'h1A;
    localparam int unsigned C_INIT_NUM_REGS = 8;
    localparam int unsigned C_IDX_W         = $clog2(C_INIT_NUM_REGS);

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } init_entry_t;

    // Reset, power management, clocking, interface format, DAC volume, unmute.
    localparam init_entry_t C_INIT_TABLE [C_INIT_NUM_REGS] = '{
        '{7'h0F, 9'h000},
        '{7'h19, 9'h0C0},
        '{7'h1A, 9'h1F8},
        '{7'h2F, 9'h00C},
        '{7'h04, 9'h000},
        '{7'h07, 9'h002},
        '{7'h0A, 9'h1FF},
        '{7'h05, 9'h000}
    };

    typedef enum logic [3:0] {
        S_IDLE, S_POWERUP, S_ISSUE, S_WAIT_RSP, S_GAP, S_DONE, S_ERROR
`ifdef WM8960_INIT_READBACK_EN
        , S_RB_ISSUE, S_RB_WAIT
`endif
    } state_t;

    function automatic init_entry_t init_entry(input logic [7:0] idx);
        init_entry_t e;
        e = '0;
        if (idx < 8'(C_INIT_NUM_REGS)) begin
            e = C_INIT_TABLE[idx[C_IDX_W-1:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/wm8960_init_seq_if.sv
// Command and response streams between the init sequencer and the I2C master.
interface wm8960_init_seq_if;
    logic [6:0] cmd_device_address;
    logic       cmd_rd_wr;
    logic [6:0] cmd_register_address;
    logic [8:0] cmd_register_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] rsp_register_data;
    logic [2:0] rsp_acks_received;
    logic       rsp_valid;
    logic       rsp_ready;

    modport master (
        output cmd_device_address, cmd_rd_wr, cmd_register_address, cmd_register_data, cmd_valid,
        input  cmd_ready,
        input  rsp_register_data, rsp_acks_received, rsp_valid,
        output rsp_ready
    );

    modport slave (
        input  cmd_device_address, cmd_rd_wr, cmd_register_address, cmd_register_data, cmd_valid,
        output cmd_ready,
        output rsp_register_data, rsp_acks_received, rsp_valid,
        input  rsp_ready
    );
endinterface

// File: rtl/wm8960_delay_cnt.sv
// Loadable 16-bit down-counter; done is high in the last cycle of the loaded interval.
module wm8960_delay_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic        done
);
    logic [15:0] count_q, count_d;

    // A zero load would never expire, so it is stretched to a single cycle.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = (load_value == 16'd0) ? 16'd1 : load_value;
        end else if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign done = (count_q == 16'd1);
endmodule

// File: rtl/wm8960_init_seq.sv
// Walks the WM8960 init table over the I2C command stream, with per-entry retries.
// Define WM8960_INIT_READBACK_EN to verify each write with a read of the same register.
module wm8960_init_seq
    import wm8960_pkg::*;
#(
    parameter logic [6:0] G_DEVICE_ADDRESS = C_WM8960_ADDR,
    parameter int         G_POWERUP_CYCLES = 1000,
    parameter int         G_GAP_CYCLES     = 100,
    parameter int         G_MAX_RETRIES    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       fail_index,
    wm8960_init_seq_if.master bus
);
    localparam logic [15:0] C_PWR_LOAD = 16'(G_POWERUP_CYCLES);
    localparam logic [15:0] C_GAP_LOAD = 16'(G_GAP_CYCLES);
    localparam logic [7:0]  C_MAX_RTY  = 8'(G_MAX_RETRIES);
    localparam logic [7:0]  C_LAST_IDX = 8'(C_INIT_NUM_REGS);

    state_t      state_q, state_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  fail_q, fail_d;
    logic        run, cnt_load, cnt_done;
    logic [15:0] cnt_value;
    logic        issue_c, rd_c, rsp_rdy_c, attempt_ok, attempt_bad;
    init_entry_t entry;

    // Disable is folded into reset so every output drops in the same cycle.
    assign run   = reset & enable;
    assign entry = init_entry(index_q);

    wm8960_delay_cnt u_delay (
        .clk        (clk),
        .reset      (run),
        .load       (cnt_load),
        .load_value (cnt_value),
        .done       (cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        retry_d     = retry_q;
        fail_d      = fail_q;
        cnt_load    = 1'b0;
        cnt_value   = C_GAP_LOAD;
        issue_c     = 1'b0;
        rd_c        = 1'b0;
        rsp_rdy_c   = 1'b0;
        attempt_ok  = 1'b0;
        attempt_bad = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d   = S_POWERUP;
                    index_d   = '0;
                    retry_d   = '0;
                    fail_d    = '0;
                    cnt_load  = 1'b1;
                    cnt_value = C_PWR_LOAD;
                end
            end
            S_POWERUP: if (cnt_done) state_d = S_ISSUE;
            S_ISSUE: begin
                issue_c = 1'b1;
                if (bus.cmd_ready) state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                rsp_rdy_c = 1'b1;
                if (bus.rsp_valid) begin
                    if (bus.rsp_acks_received == 3'b111) begin
`ifdef WM8960_INIT_READBACK_EN
                        state_d = S_RB_ISSUE;
`else
                        attempt_ok = 1'b1;
`endif
                    end else begin
                        attempt_bad = 1'b1;
                    end
                end
            end
            S_GAP: if (cnt_done) state_d = (index_q == C_LAST_IDX) ? S_DONE : S_ISSUE;
`ifdef WM8960_INIT_READBACK_EN
            S_RB_ISSUE: begin
                issue_c = 1'b1;
                rd_c    = 1'b1;
                if (bus.cmd_ready) state_d = S_RB_WAIT;
            end
            S_RB_WAIT: begin
                rsp_rdy_c = 1'b1;
                if (bus.rsp_valid) begin
                    if (bus.rsp_acks_received == 3'b111 && bus.rsp_register_data == entry.data)
                        attempt_ok = 1'b1;
                    else
                        attempt_bad = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Both write and readback outcomes funnel into the same retry bookkeeping.
        if (attempt_ok) begin
            index_d  = index_q + 8'd1;
            retry_d  = '0;
            state_d  = S_GAP;
            cnt_load = 1'b1;
        end
        if (attempt_bad) begin
            if (retry_q < C_MAX_RTY) begin
                retry_d  = retry_q + 8'd1;
                state_d  = S_GAP;
                cnt_load = 1'b1;
            end else begin
                fail_d  = index_q;
                state_d = S_ERROR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            state_q <= S_IDLE;
            index_q <= '0;
            retry_q <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            retry_q <= retry_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.cmd_device_address   = G_DEVICE_ADDRESS;
    assign bus.cmd_valid            = run & issue_c;
    assign bus.cmd_rd_wr            = run & rd_c;
    assign bus.cmd_register_address = (run && issue_c) ? entry.addr : '0;
    assign bus.cmd_register_data    = (run && issue_c && !rd_c) ? entry.data : '0;
    assign bus.rsp_ready            = run & rsp_rdy_c;

    assign busy       = run && !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign done       = run && (state_q == S_DONE);
    assign error      = run && (state_q == S_ERROR);
    assign fail_index = run ? fail_q : '0;

`ifndef WM8960_INIT_READBACK_EN
    logic unused_rsp_data;
    assign unused_rsp_data = ^bus.rsp_register_data;
`endif
endmodule

// File: tb/tb_wm8960_init_seq.sv
// Directed bench for wm8960_init_seq with a scripted I2C responder and a command log.
module tb_wm8960_init_seq;
    logic       clk = 1'b0;
    logic       reset, enable, start;
    logic       busy, done, error;
    logic [7:0] fail_index;

    wm8960_init_seq_if bus();

    wm8960_init_seq #(
        .G_DEVICE_ADDRESS (7'h1A),
        .G_POWERUP_CYCLES (10),
        .G_GAP_CYCLES     (4),
        .G_MAX_RETRIES    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .fail_index (fail_index),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] exp_addr [8] = '{7'h0F, 7'h19, 7'h1A, 7'h2F, 7'h04, 7'h07, 7'h0A, 7'h05};
    logic [8:0] exp_data [8] = '{9'h000, 9'h0C0, 9'h1F8, 9'h00C, 9'h000, 9'h002, 9'h1FF, 9'h000};

    int n_chk = 0;
    int n_bad = 0;

    // Responder policy, written by the main thread.
    logic       ready_hold = 1'b0;
    logic [6:0] fail_addr  = 7'h7F;
    int         fail_times = 0;
    logic [2:0] bad_acks   = 3'b111;
    int         policy_id  = 0;

    // Responder state and command log, owned by the responder.
    logic [16:0] log_cmd [256];
    int          log_n     = 0;
    int          seen_id   = 0;
    int          fail_seen = 0;
    logic        pending   = 1'b0;
    logic        drop_next = 1'b0;
    int          rsp_wait  = 0;
    logic [2:0]  pend_acks = 3'b111;

    always @(negedge clk) begin
        if (policy_id != seen_id) begin
            seen_id   = policy_id;
            fail_seen = 0;
        end
        bus.cmd_ready         = !ready_hold;
        bus.rsp_register_data = '0;
        if (!reset || !enable) begin
            bus.rsp_valid         = 1'b0;
            bus.rsp_acks_received = '0;
            pending               = 1'b0;
            drop_next             = 1'b0;
        end else if (drop_next) begin
            bus.rsp_valid = 1'b0;
            drop_next     = 1'b0;
        end else begin
            if (pending) begin
                if (rsp_wait == 0) begin
                    bus.rsp_valid         = 1'b1;
                    bus.rsp_acks_received = pend_acks;
                    pending               = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) drop_next = 1'b1;
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (log_n < 256) log_cmd[log_n] = {bus.cmd_rd_wr, bus.cmd_register_address, bus.cmd_register_data};
                log_n++;
                if (bus.cmd_register_address == fail_addr && fail_seen < fail_times) begin
                    pend_acks = bad_acks;
                    fail_seen++;
                end else begin
                    pend_acks = 3'b111;
                end
                pending  = 1'b1;
                rsp_wait = 2;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && !(done || error); i++) step();
    endtask

    function automatic logic [16:0] exp_cmd(input int i);
        return {1'b0, exp_addr[i], exp_data[i]};
    endfunction

    function automatic logic [16:0] cur_cmd();
        return {bus.cmd_rd_wr, bus.cmd_register_address, bus.cmd_register_data};
    endfunction

    int          base, lat, unstable;
    logic [16:0] cap;
    int          s3_seq [10] = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 7};
    int          s4_seq [8]  = '{0, 1, 2, 3, 4, 4, 4, 4};

    initial begin
        reset = 1'b0;
        enable = 1'b1;
        start = 1'b0;

        // Reset values
        repeat (5) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_fail_index", fail_index, 0);
        chk("rst_cmd_valid", bus.cmd_valid, 0);
        chk("rst_cmd_fields", cur_cmd(), 0);
        chk("rst_rsp_ready", bus.rsp_ready, 0);
        chk("rst_dev_addr", bus.cmd_device_address, 7'h1A);
        reset = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Clean run, with a start pulse mid-sequence that must be ignored
        base = log_n;
        start = 1'b1;
        lat = 0;
        for (int i = 0; i < 100 && !bus.cmd_valid; i++) begin
            step();
            start = 1'b0;
            lat++;
            if (lat == 1) chk("s2_busy_after_start", busy, 1);
        end
        chk("s2_powerup_latency", lat, 11);
        chk("s2_first_cmd", cur_cmd(), exp_cmd(0));
        start_pulse();
        wait_end(2000);
        chk("s2_done", done, 1);
        chk("s2_busy", busy, 0);
        chk("s2_error", error, 0);
        chk("s2_count", log_n - base, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("s2_cmd%0d", i), log_cmd[base + i], exp_cmd(i));

        // Entry 2 nacked twice, then acked
        fail_addr = exp_addr[2];
        fail_times = 2;
        bad_acks = 3'b101;
        policy_id++;
        base = log_n;
        start_pulse();
        chk("s3_done_cleared", done, 0);
        wait_end(3000);
        chk("s3_done", done, 1);
        chk("s3_error", error, 0);
        chk("s3_count", log_n - base, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("s3_cmd%0d", i), log_cmd[base + i], exp_cmd(s3_seq[i]));

        // Entry 4 never acked: retry budget exhausted
        fail_addr = exp_addr[4];
        fail_times = 1000;
        bad_acks = 3'b011;
        policy_id++;
        base = log_n;
        start_pulse();
        wait_end(3000);
        chk("s4_error", error, 1);
        chk("s4_fail_index", fail_index, 4);
        chk("s4_done", done, 0);
        chk("s4_busy", busy, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("s4_cmd%0d", i), log_cmd[base + i], exp_cmd(s4_seq[i]));
        repeat (30) step();
        chk("s4_count", log_n - base, 8);
        chk("s4_error_sticky", error, 1);

        // Back-pressure on the command stream
        fail_addr = 7'h7F;
        fail_times = 0;
        policy_id++;
        ready_hold = 1'b1;
        base = log_n;
        start_pulse();
        chk("s5_error_cleared", error, 0);
        chk("s5_fail_index_cleared", fail_index, 0);
        for (int i = 0; i < 100 && !bus.cmd_valid; i++) step();
        chk("s5_valid", bus.cmd_valid, 1);
        cap = cur_cmd();
        chk("s5_cap", cap, exp_cmd(0));
        unstable = 0;
        repeat (50) begin
            step();
            if (!bus.cmd_valid || cur_cmd() !== cap) unstable++;
        end
        chk("s5_hold_stable", unstable, 0);
        chk("s5_no_xfer", log_n - base, 0);
        ready_hold = 1'b0;
        repeat (3) step();
        chk("s5_one_xfer", log_n - base, 1);
        chk("s5_xfer_cmd", log_cmd[base], exp_cmd(0));
        wait_end(2000);
        chk("s5_done", done, 1);
        chk("s5_count", log_n - base, 8);

        // Reset while waiting for a response
        base = log_n;
        start_pulse();
        for (int i = 0; i < 100 && !bus.rsp_ready; i++) step();
        chk("s6_in_wait", bus.rsp_ready, 1);
        reset = 1'b0;
        #1;
        chk("s6_rsp_ready_gated", bus.rsp_ready, 0);
        step();
        reset = 1'b1;
        #1;
        chk("s6_idle_busy", busy, 0);
        chk("s6_idle_rsp_ready", bus.rsp_ready, 0);
        chk("s6_idle_cmd_valid", bus.cmd_valid, 0);
        chk("s6_partial_count", log_n - base, 1);
        base = log_n;
        start_pulse();
        for (int i = 0; i < 100 && log_n == base; i++) step();
        chk("s6_restart_cmd", log_cmd[base], exp_cmd(0));
        wait_end(2000);
        chk("s6_done", done, 1);
        chk("s6_count", log_n - base, 8);

        // Enable low behaves as reset
        enable = 1'b0;
        #1;
        chk("en_done_gated", done, 0);
        step();
        enable = 1'b1;
        #1;
        chk("en_idle_done", done, 0);
        chk("en_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
